fix_msg_serializer: RTL
=======================

# fix_msg_serializer

Parametrised FIX field serializer. It replaces the fixed-width tag/value byte emitter between the message builder and the transport. It accepts one tag/value field per handshake and emits `tag '=' value SOH` as an ASCII byte stream with valid/ready backpressure. It also keeps a running CheckSum (tag 10) and BodyLength count, and on request appends the `10=nnn SOH` trailer computed in hardware.

## Interface
- VALUE_WIDTH, 256, value field width in bits; max value bytes VB = VALUE_WIDTH/8
- TAG_WIDTH, 32, tag field width in bits; max tag bytes TB = TAG_WIDTH/8
- SIZE, 64, width of value byte-count input
- T_SIZE, 5, width of tag byte-count input
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- field_valid_i  in  1  field offered
- field_ready_o  out  1  field accepted when valid && ready
- tag_i  in  TAG_WIDTH  ASCII tag, right-aligned
- t_size_i  in  T_SIZE  tag byte count
- val_i  in  VALUE_WIDTH  ASCII value, right-aligned
- v_size_i  in  SIZE  value byte count
- body_i  in  1  field's bytes count toward BodyLength
- checksum_i  in  1  field is a trailer request; tag/val/sizes/body_i ignored
- data_o  out  8  output byte
- data_valid_o  out  1  data_o valid
- data_ready_i  in  1  sink accepts byte
- last_o  out  1  qualifies the trailer's SOH byte
- checksum_o  out  8  running sum mod 256 of transferred bytes since last trailer
- body_len_o  out  16  running BodyLength since last trailer
- error_o  out  1  one-cycle pulse: bad field sizes

## Operation
- Reset values: all outputs 0; state IDLE; checksum and body counters 0; field_ready_o 0 during reset and 1 in IDLE after reset.
- field_ready_o = (state == IDLE). Accepted inputs are registered; inputs are don't-care afterwards.
- Byte order: tag byte k (k = 0..t_size-1) = tag_i[8*(t_size-1-k) +: 8]. Value bytes use the same rule with v_size. First character is most significant.
- States and transitions:
  - IDLE: on accept, go to TAG, or to CK_HDR if checksum_i.
  - TAG: emit t_size bytes, then go to EQ.
  - EQ: emit 0x3D, then go to VAL.
  - VAL: emit v_size bytes, then go to SOH.
  - SOH: emit 0x01, then go to IDLE.
  - CK_HDR: emit 0x31 0x30 0x3D, then go to CK_DIG.
  - CK_DIG: emit 3 digits, then go to CK_SOH.
  - CK_SOH: emit 0x01 with last_o=1, then go to IDLE.
- A byte advances only on data_valid_o && data_ready_i. data_o and last_o hold stable while valid && !ready.
- Checksum:
  - On each transferred byte of a normal field, checksum_o += byte mod 256.
  - Trailer bytes are not summed.
  - On CK_HDR entry, the current sum is latched. The digits are the hundreds, tens, and units of that sum, each plus 0x30, zero-padded.
  - After the trailer SOH transfers, checksum_o and body_len_o clear to 0 in the same cycle.
- BodyLength: when a transferred byte belongs to a field accepted with body_i=1, body_len_o += 1, wrapping mod 2^16.
- Size errors:
  - Error conditions: t_size_i == 0, t_size_i > TB, v_size_i == 0, or v_size_i > VB (checked only when checksum_i=0).
  - On error the field is still accepted, but no bytes are emitted and the counters are unchanged.
  - error_o pulses the cycle after accept, and the state stays IDLE.
- Reset mid-field: everything returns to reset values immediately, and the partial field is dropped.

## Timing
- Field accepted in cycle N: first byte valid in cycle N+1.
- With data_ready_i held at 1, a field occupies t_size+v_size+2 cycles. field_ready_o rises the cycle after the SOH transfers, so there is a 1-cycle bubble per field.
- A trailer occupies 7 cycles plus the bubble.
- checksum_o and body_len_o update the cycle after each byte transfer.

## Test plan
- **Single field.** tag_i=32'h3335, t_size=2, val_i=...41, v_size=1, body_i=1, ready held 1. Required: bytes 33 35 3D 41 01 on consecutive cycles starting N+1; checksum_o=0xE7; body_len_o=5.
- **Trailer.** Following the single field, send checksum_i=1. Required: bytes 31 30 3D 32 33 31 01, with last_o only on the final 01. Afterwards checksum_o=0 and body_len_o=0.
- **Backpressure.** Single field with data_ready_i toggling 1,0,0,1... Required: each byte held stable while ready=0; the sequence is identical; no byte is duplicated or lost.
- **Wrap and zero-pad.** Fields "8=FIX.4.2" then "9=5" with body_i=0, then "35=A" with body_i=1. Required: trailer digits equal the byte sum mod 256, zero-padded to 3 digits; body_len_o=5 before the trailer.
- **Size error.** v_size_i=0, and separately v_size_i=VB+1. Required: error_o pulses once, no data_valid_o, counters unchanged, next valid field serializes normally.
- **Reset mid-field.** Assert rst low during the VAL state. Required: data_valid_o drops asynchronously, all outputs are 0; after release, field_ready_o=1 and a new field emits from its first byte.

Source files
------------

// File: rtl/fix_msg_serializer_if.sv
// Field-in / byte-out handshake bundle for the FIX field serializer.
// The slave modport is the serializer; the master modport is the
// message builder plus transport sink that surround it.
interface fix_msg_serializer_if #(
    parameter int VALUE_WIDTH = 256,
    parameter int TAG_WIDTH   = 32,
    parameter int SIZE        = 64,
    parameter int T_SIZE      = 5
);
    logic                   field_valid_i;
    logic                   field_ready_o;
    logic [TAG_WIDTH-1:0]   tag_i;
    logic [T_SIZE-1:0]      t_size_i;
    logic [VALUE_WIDTH-1:0] val_i;
    logic [SIZE-1:0]        v_size_i;
    logic                   body_i;
    logic                   checksum_i;
    logic [7:0]             data_o;
    logic                   data_valid_o;
    logic                   data_ready_i;
    logic                   last_o;
    logic [7:0]             checksum_o;
    logic [15:0]            body_len_o;
    logic                   error_o;

    modport slave (
        input  field_valid_i, tag_i, t_size_i, val_i, v_size_i, body_i,
               checksum_i, data_ready_i,
        output field_ready_o, data_o, data_valid_o, last_o, checksum_o,
               body_len_o, error_o
    );

    modport master (
        output field_valid_i, tag_i, t_size_i, val_i, v_size_i, body_i,
               checksum_i, data_ready_i,
        input  field_ready_o, data_o, data_valid_o, last_o, checksum_o,
               body_len_o, error_o
    );
endinterface

// File: rtl/fix_msg_serializer.sv
// FIX field serializer: turns one tag/value field per handshake into the
// ASCII stream "tag=value<SOH>", keeps a running CheckSum and BodyLength,
// and on request emits the "10=nnn<SOH>" trailer from the running sum.
module fix_msg_serializer #(
    parameter int VALUE_WIDTH = 256,
    parameter int TAG_WIDTH   = 32,
    parameter int SIZE        = 64,
    parameter int T_SIZE      = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    fix_msg_serializer_if.slave   bus
);
    localparam int VB   = VALUE_WIDTH / 8;
    localparam int TB   = TAG_WIDTH / 8;
    localparam int MAXB = (VB > TB) ? VB : TB;
    localparam int CW   = $clog2(((MAXB > 3) ? MAXB : 3) + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_TAG, S_EQ, S_VAL, S_SOH, S_CK_HDR, S_CK_DIG, S_CK_SOH
    } state_t;

    state_t                 r_state;
    logic [TAG_WIDTH-1:0]   r_tag;
    logic [VALUE_WIDTH-1:0] r_val;
    logic [CW-1:0]          r_left;
    logic [CW-1:0]          r_vsize;
    logic                   r_body;
    logic [39:0]            r_trl;
    logic [7:0]             r_data;
    logic                   r_valid;
    logic                   r_last;
    logic                   r_field_ready;
    logic [7:0]             r_sum;
    logic [15:0]            r_body_len;
    logic                   r_error;

    logic                   w_accept;
    logic                   w_xfer;
    logic                   w_size_bad;
    logic [TAG_WIDTH-1:0]   w_tag_aligned;
    logic [VALUE_WIDTH-1:0] w_val_aligned;
    logic [7:0]             w_d2;
    logic [7:0]             w_d1;
    logic [7:0]             w_d0;

    // Accept/transfer qualifiers, size check, left-alignment and trailer digits.
    // Fields are left-aligned into shift registers at accept so the byte on the
    // wire is always the top byte, giving first-character-most-significant order.
    always_comb begin
        w_accept      = bus.field_valid_i && r_field_ready;
        w_xfer        = r_valid && bus.data_ready_i;
        w_size_bad    = (bus.t_size_i == '0) || (bus.t_size_i > T_SIZE'(TB)) ||
                        (bus.v_size_i == '0) || (bus.v_size_i > SIZE'(VB));
        w_tag_aligned = bus.tag_i << (8 * (TB - int'(bus.t_size_i)));
        w_val_aligned = bus.val_i << (8 * (VB - int'(bus.v_size_i)));
        w_d2          = 8'h30 + (r_sum / 8'd100);
        w_d1          = 8'h30 + ((r_sum / 8'd10) % 8'd10);
        w_d0          = 8'h30 + (r_sum % 8'd10);
    end

    // Field/trailer sequencer with registered byte, handshake and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_tag         <= '0;
            r_val         <= '0;
            r_left        <= '0;
            r_vsize       <= '0;
            r_body        <= 1'b0;
            r_trl         <= '0;
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_last        <= 1'b0;
            r_field_ready <= 1'b0;
            r_sum         <= '0;
            r_body_len    <= '0;
            r_error       <= 1'b0;
        end else begin
            r_error <= 1'b0;
            if (r_state == S_IDLE) begin
                r_field_ready <= 1'b1;
                if (w_accept) begin
                    if (bus.checksum_i) begin
                        r_state       <= S_CK_HDR;
                        r_data        <= 8'h31;
                        r_trl         <= {8'h30, 8'h3D, w_d2, w_d1, w_d0};
                        r_left        <= CW'(3);
                        r_valid       <= 1'b1;
                        r_last        <= 1'b0;
                        r_field_ready <= 1'b0;
                    end else if (w_size_bad) begin
                        r_error <= 1'b1;
                    end else begin
                        r_state       <= S_TAG;
                        r_data        <= w_tag_aligned[TAG_WIDTH-1 -: 8];
                        r_tag         <= w_tag_aligned << 8;
                        r_val         <= w_val_aligned;
                        r_left        <= CW'(bus.t_size_i);
                        r_vsize       <= CW'(bus.v_size_i);
                        r_body        <= bus.body_i;
                        r_valid       <= 1'b1;
                        r_last        <= 1'b0;
                        r_field_ready <= 1'b0;
                    end
                end
            end else if (w_xfer) begin
                if (r_state inside {S_TAG, S_EQ, S_VAL, S_SOH}) begin
                    r_sum <= r_sum + r_data;
                    if (r_body) begin
                        r_body_len <= r_body_len + 16'd1;
                    end
                end
                case (r_state)
                    S_TAG: begin
                        if (r_left == CW'(1)) begin
                            r_state <= S_EQ;
                            r_data  <= 8'h3D;
                        end else begin
                            r_data <= r_tag[TAG_WIDTH-1 -: 8];
                            r_tag  <= r_tag << 8;
                            r_left <= r_left - CW'(1);
                        end
                    end
                    S_EQ: begin
                        r_state <= S_VAL;
                        r_data  <= r_val[VALUE_WIDTH-1 -: 8];
                        r_val   <= r_val << 8;
                        r_left  <= r_vsize;
                    end
                    S_VAL: begin
                        if (r_left == CW'(1)) begin
                            r_state <= S_SOH;
                            r_data  <= 8'h01;
                        end else begin
                            r_data <= r_val[VALUE_WIDTH-1 -: 8];
                            r_val  <= r_val << 8;
                            r_left <= r_left - CW'(1);
                        end
                    end
                    S_SOH: begin
                        r_state       <= S_IDLE;
                        r_data        <= '0;
                        r_valid       <= 1'b0;
                        r_field_ready <= 1'b1;
                    end
                    S_CK_HDR: begin
                        r_data <= r_trl[39:32];
                        r_trl  <= {r_trl[31:0], 8'h00};
                        if (r_left == CW'(1)) begin
                            r_state <= S_CK_DIG;
                            r_left  <= CW'(3);
                        end else begin
                            r_left <= r_left - CW'(1);
                        end
                    end
                    S_CK_DIG: begin
                        if (r_left == CW'(1)) begin
                            r_state <= S_CK_SOH;
                            r_data  <= 8'h01;
                            r_last  <= 1'b1;
                        end else begin
                            r_data <= r_trl[39:32];
                            r_trl  <= {r_trl[31:0], 8'h00};
                            r_left <= r_left - CW'(1);
                        end
                    end
                    S_CK_SOH: begin
                        r_state       <= S_IDLE;
                        r_data        <= '0;
                        r_valid       <= 1'b0;
                        r_last        <= 1'b0;
                        r_field_ready <= 1'b1;
                        r_sum         <= '0;
                        r_body_len    <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.field_ready_o = r_field_ready;
    assign bus.data_o        = r_data;
    assign bus.data_valid_o  = r_valid;
    assign bus.last_o        = r_last;
    assign bus.checksum_o    = r_sum;
    assign bus.body_len_o    = r_body_len;
    assign bus.error_o       = r_error;
endmodule
